rtdf_sample_packer: RTL

- Packs narrow front-end GPS samples into 16-bit words and drives the write side of the RTDF stream FIFO (16-bit data, 9-bit used-words, show-ahead).
- Frames the stream: one header word, then FRAME_WORDS data words, repeating.
- On FIFO overflow it drops data, records the drop, and resynchronises on a fresh frame header once the FIFO has drained.
- Runs entirely in the FIFO write-clock domain.

---
 rtl/rtdf_sample_packer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rtdf_sample_packer.sv
// rtdf_sample_packer
//   Packs SAMPLE_BITS-wide front-end samples into 16-bit words and drives the
//   write side of the RTDF stream FIFO. The stream is framed as one header word
//   {SYNC_BYTE, seq} followed by FRAME_WORDS data words, repeating. A write that
//   meets a full FIFO is dropped and counted; the packer then waits for the FIFO
//   to drain to RESUME_LEVEL and restarts on a fresh header.
//
// Ports
//   clk, reset        write-side clock, asynchronous active-high reset
//   enable            stream enable; low returns to IDLE and discards any partial word
//   sample_valid      sample_data is valid this cycle
//   sample_data       front-end sample, first sample of a word lands in the MSBs
//   fifo_full         FIFO wrfull
//   fifo_usedw        FIFO wrusedw
//   clear_overflow    one-cycle pulse clearing overflow and drop_count
//   fifo_data         registered FIFO write data
//   fifo_wrreq        registered FIFO write request, one cycle per word
//   overflow          sticky: at least one word was dropped
//   drop_count        dropped-word count, saturating at 16'hFFFF
//   seq_num           sequence number of the most recent header written
module rtdf_sample_packer #(
    parameter int unsigned SAMPLE_BITS  = 2,
    parameter int unsigned FRAME_WORDS  = 64,
    parameter int unsigned RESUME_LEVEL = 128,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_valid,
    input  logic [SAMPLE_BITS-1:0] sample_data,
    input  logic                   fifo_full,
    input  logic [8:0]             fifo_usedw,
    input  logic                   clear_overflow,
    output logic [15:0]            fifo_data,
    output logic                   fifo_wrreq,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [7:0]             seq_num
);

    localparam int unsigned SPW = 16 / SAMPLE_BITS;
    localparam int unsigned PCW = $clog2(SPW);

    localparam logic [PCW-1:0] PACK_LAST    = PCW'(SPW - 1);
    localparam logic [15:0]    FRAME_LAST   = 16'(FRAME_WORDS - 1);
    localparam logic [8:0]     RESUME_USEDW = 9'(RESUME_LEVEL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        STREAM = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t           state;
    logic [PCW-1:0]   pack_cnt;
    logic [15:0]      shift_reg;
    logic [15:0]      word_cnt;
    logic [7:0]       seq;

    logic             sample_take;
    logic             word_done;
    logic [15:0]      packed_word;
    logic [15:0]      drop_next;

    // Samples are packed only while a frame is live (header cycle included).
    assign sample_take = enable && sample_valid && (state == HEADER || state == STREAM);
    assign word_done   = sample_take && (pack_cnt == PACK_LAST);
    assign packed_word = {shift_reg[15-SAMPLE_BITS:0], sample_data};

    // A drop coinciding with clear_overflow restarts the count at one.
    assign drop_next = clear_overflow          ? 16'd1 :
                       (drop_count == 16'hFFFF) ? 16'hFFFF :
                                                  drop_count + 16'd1;

    // Framing FSM, packer and registered FIFO write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pack_cnt   <= '0;
            shift_reg  <= '0;
            word_cnt   <= '0;
            seq        <= '0;
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            seq_num    <= '0;
        end else begin
            fifo_wrreq <= 1'b0;

            if (clear_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end

            if (!enable) begin
                state    <= IDLE;
                pack_cnt <= '0;
                shift_reg <= '0;
                word_cnt <= '0;
            end else begin
                if (sample_take) begin
                    shift_reg <= packed_word;
                    pack_cnt  <= word_done ? '0 : pack_cnt + PCW'(1);
                end

                case (state)
                    IDLE: begin
                        state <= HEADER;
                    end

                    HEADER: begin
                        word_cnt <= '0;
                        if (fifo_full) begin
                            overflow   <= 1'b1;
                            drop_count <= drop_next;
                            state      <= RESYNC;
                            pack_cnt   <= '0;
                            shift_reg  <= '0;
                        end else begin
                            fifo_wrreq <= 1'b1;
                            fifo_data  <= {SYNC_BYTE, seq};
                            seq_num    <= seq;
                            seq        <= seq + 8'd1;
                            state      <= STREAM;
                        end
                    end

                    STREAM: begin
                        if (word_done) begin
                            if (fifo_full) begin
                                overflow   <= 1'b1;
                                drop_count <= drop_next;
                                state      <= RESYNC;
                                pack_cnt   <= '0;
                                shift_reg  <= '0;
                            end else begin
                                fifo_wrreq <= 1'b1;
                                fifo_data  <= packed_word;
                                if (word_cnt == FRAME_LAST) begin
                                    word_cnt <= '0;
                                    state    <= HEADER;
                                end else begin
                                    word_cnt <= word_cnt + 16'd1;
                                end
                            end
                        end
                    end

                    RESYNC: begin
                        // Partial frame is abandoned; restart on a fresh header once drained.
                        pack_cnt  <= '0;
                        shift_reg <= '0;
                        if (!fifo_full && fifo_usedw <= RESUME_USEDW)
                            state <= HEADER;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
